// File: rtl/func_sweep_ctrl_if.sv
// func_sweep_ctrl_if: control, stimulus and result signals between a sweep controller and its user
interface func_sweep_ctrl_if;
  logic       start;
  logic       abort;
  logic       z_in;
  logic       x_0;
  logic       x_1;
  logic       x_2;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_count;
  logic [7:0] err_mask;
  modport master (output start, abort, z_in,
                  input  x_0, x_1, x_2, busy, done, pass, err_count, err_mask);
  modport slave  (input  start, abort, z_in,
                  output x_0, x_1, x_2, busy, done, pass, err_count, err_mask);
endinterface

// File: rtl/func_sweep_ctrl.sv
// func_sweep_ctrl: sweeps all 8 vectors of a 3-input function and checks z_in against a truth table
module func_sweep_ctrl #(
  parameter logic [7:0] TRUTH_TABLE = 8'b01000011,
  parameter int         STEP_CYCLES = 2
) (
  input logic             clock,
  input logic             reset,
  func_sweep_ctrl_if.slave bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] CHECK  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;
  localparam logic [3:0] LAST   = 4'(STEP_CYCLES - 1);
  logic [1:0] state_q, state_d;
  logic [2:0] idx_q, idx_d, x_q, x_d;
  logic [3:0] cnt_q, cnt_d, err_count_q, err_count_d;
  logic [7:0] err_mask_q, err_mask_d;
  logic       pass_q, pass_d;
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    err_count_d = err_count_q;
    err_mask_d  = err_mask_q;
    pass_d      = pass_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d     = SETTLE;
        idx_d       = 3'd0;
        cnt_d       = 4'd0;
        err_count_d = 4'd0;
        err_mask_d  = 8'd0;
        pass_d      = 1'b0;
      end
      SETTLE: begin
        state_d = bus.abort ? IDLE : (cnt_q == LAST) ? CHECK : SETTLE;
        cnt_d   = cnt_q + 4'd1;
      end
      CHECK: if (bus.abort) state_d = IDLE;
      else begin
        if (bus.z_in != TRUTH_TABLE[idx_q]) begin
          err_mask_d[idx_q] = 1'b1;
          err_count_d       = err_count_q + 4'd1;
        end
        state_d = (idx_q == 3'd7) ? DONE : SETTLE;
        idx_d   = (idx_q == 3'd7) ? idx_q : idx_q + 3'd1;
        cnt_d   = 4'd0;
      end
      DONE: begin
        state_d = IDLE;
        pass_d  = (err_count_q == 4'd0);
      end
    endcase
    // Stimulus is registered and forced back to zero outside the active sweep
    x_d = (state_d == SETTLE || state_d == CHECK) ? idx_d : 3'd0;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= 3'd0;
      cnt_q       <= 4'd0;
      x_q         <= 3'd0;
      err_count_q <= 4'd0;
      err_mask_q  <= 8'd0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      err_count_q <= err_count_d;
      err_mask_q  <= err_mask_d;
      pass_q      <= pass_d;
    end
  assign {bus.x_2, bus.x_1, bus.x_0} = x_q;
  assign bus.busy      = (state_q == SETTLE) || (state_q == CHECK);
  assign bus.done      = (state_q == DONE);
  assign bus.pass      = pass_q;
  assign bus.err_count = err_count_q;
  assign bus.err_mask  = err_mask_q;
endmodule

// File: tb/tb_func_sweep_ctrl.sv
// tb_func_sweep_ctrl: directed and randomized sweeps checked against a truth-table mismatch model
module tb_func_sweep_ctrl;
  localparam logic [7:0] TT = 8'b01000011;
  localparam int         S  = 2;
  localparam int         N  = 8 * (S + 1);
  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] fut;
  int         tests = 0;
  int         fails = 0;
  func_sweep_ctrl_if bus ();
  func_sweep_ctrl #(.TRUTH_TABLE(TT), .STEP_CYCLES(S)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  // Function under test: fut is its truth table, indexed by the stimulus vector
  assign bus.z_in = fut[{bus.x_2, bus.x_1, bus.x_0}];
  function automatic int popc(input logic [7:0] m);
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(m[i]);
    return c;
  endfunction
  function automatic logic [7:0] lowm(input int v);
    logic [8:0] one = 9'd1;
    return 8'((one << v) - 9'd1);
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk_results(input string tag, input logic [7:0] m, input logic p);
    chk({tag, "_mask"}, bus.err_mask, m);
    chk({tag, "_cnt"}, bus.err_count, popc(m));
    chk({tag, "_pass"}, bus.pass, p);
  endtask
  // One sweep from a start pulse; optional abort in vector abort_v at offset abort_off, restart held during restart_v
  task automatic sweep(input int abort_v, input int abort_off, input int restart_v);
    logic [7:0] mism = fut ^ TT;
    @(negedge clock) bus.start = 1'b1;
    @(negedge clock) bus.start = 1'b0;
    for (int i = 0; i < N; i++) begin
      int v = i / (S + 1);
      chk("x", {bus.x_2, bus.x_1, bus.x_0}, v);
      chk("busy", bus.busy, 1);
      chk("done_early", bus.done, 0);
      chk_results("run", mism & lowm(v), 1'b0);
      bus.abort = (v == abort_v) && (i % (S + 1) == abort_off);
      bus.start = (v == restart_v);
      @(negedge clock);
      if (bus.abort) begin
        bus.abort = 1'b0;
        for (int j = 0; j < 3; j++) begin
          chk("abort_busy", bus.busy, 0);
          chk("abort_done", bus.done, 0);
          chk("abort_x", {bus.x_2, bus.x_1, bus.x_0}, 0);
          chk_results("abort", mism & lowm(v), 1'b0);
          @(negedge clock);
        end
        return;
      end
    end
    chk("done", bus.done, 1);
    chk("done_busy", bus.busy, 0);
    chk("done_x", {bus.x_2, bus.x_1, bus.x_0}, 0);
    chk_results("done", mism, 1'b0);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    for (int j = 0; j < 3; j++) begin
      chk("idle_done", bus.done, 0);
      chk("idle_busy", bus.busy, 0);
      chk_results("final", mism, mism == 8'd0);
      @(negedge clock);
    end
  endtask
  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    fut = TT;
    repeat (3) @(negedge clock);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_x", {bus.x_2, bus.x_1, bus.x_0}, 0);
    chk_results("rst", 8'd0, 1'b0);
    reset = 1'b0;
    @(negedge clock);
    sweep(-1, 0, -1);
    fut = 8'h00;
    sweep(-1, 0, -1);
    chk("stuck0_mask", bus.err_mask, 8'b01000011);
    fut = 8'hFF;
    sweep(-1, 0, -1);
    chk("stuck1_mask", bus.err_mask, 8'b10111100);
    fut = TT;
    sweep(-1, 0, 3);
    fut = 8'h00;
    sweep(4, 0, -1);
    chk("abort4_mask", bus.err_mask, 8'b00000011);
    bus.abort = 1'b1;
    @(negedge clock) bus.abort = 1'b0;
    chk("idle_abort_busy", bus.busy, 0);
    chk_results("idle_abort", 8'b00000011, 1'b0);
    @(negedge clock) bus.start = 1'b1;
    @(negedge clock) bus.start = 1'b0;
    repeat (5 * (S + 1)) @(negedge clock);
    chk("pre_rst_x", {bus.x_2, bus.x_1, bus.x_0}, 5);
    #2 reset = 1'b1;
    #1;
    chk("async_busy", bus.busy, 0);
    chk("async_done", bus.done, 0);
    chk("async_x", {bus.x_2, bus.x_1, bus.x_0}, 0);
    chk_results("async", 8'd0, 1'b0);
    @(negedge clock) reset = 1'b0;
    fut = TT ^ 8'h10;
    sweep(-1, 0, -1);
    for (int r = 0; r < 8; r++) begin
      fut = 8'($urandom);
      sweep(($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1, int'($urandom_range(0, S)), -1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/func_sweep_ctrl.md
FUNC_SWEEP_CTRL -- requirements
Module: func_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter TRUTH_TABLE, default 8'b01000011, giving the expected function output at bit index {x_2,x_1,x_0}.
REQ-002 The block SHALL have parameter STEP_CYCLES, default 2, giving settle cycles per vector; legal range 1..15.
REQ-003 Port clock, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port start, input, 1 bit: request one full sweep of all 8 input vectors.
REQ-006 Port abort, input, 1 bit: synchronous cancel of a running sweep.
REQ-007 Port z_in, input, 1 bit: output of the function under test, combinationally driven from x_2..x_0.
REQ-008 Ports x_0, x_1, x_2, output, 1 bit each: registered stimulus to the function under test.
REQ-009 Port busy, output, 1 bit: sweep in progress.
REQ-010 Port done, output, 1 bit: one-cycle pulse at sweep completion.
REQ-011 Port pass, output, 1 bit: last completed sweep had zero mismatches.
REQ-012 Port err_count, output, 4 bits: mismatch count of current/last sweep, 0..8.
REQ-013 Port err_mask, output, 8 bits: bit i set when vector i mismatched.

Function
REQ-014 FSM states SHALL be IDLE, SETTLE, CHECK, DONE.
REQ-015 IDLE: start=1 at an edge -> SETTLE; vector index idx=0; err_count, err_mask, pass cleared on the same edge.
REQ-016 SETTLE: x_2..x_0 = idx, held for exactly STEP_CYCLES cycles, then -> CHECK.
REQ-017 CHECK: one cycle; x unchanged; compare z_in with TRUTH_TABLE[idx]; on mismatch set err_mask[idx] and increment err_count at the closing edge.
REQ-018 CHECK exit: idx<7 -> idx+1, SETTLE; idx==7 -> DONE.
REQ-019 DONE: one cycle, done=1, pass=(err_count==0) registered at the exiting edge; -> IDLE.
REQ-020 Latency: start sampled at edge k -> busy=1 from k+1; done=1 in cycle k+1+8*(STEP_CYCLES+1) (k+25 at default).
REQ-021 busy SHALL be 1 in SETTLE and CHECK, 0 in IDLE and DONE.
REQ-022 start while not IDLE SHALL be ignored (no restart, no queueing); start in DONE cycle ignored.
REQ-023 abort in SETTLE or CHECK -> IDLE at next edge; no done pulse; pass stays 0; err_count/err_mask hold partial values; abort takes priority over CHECK update that cycle.
REQ-024 abort in IDLE or DONE SHALL have no effect.
REQ-025 x_2..x_0 SHALL return to 3'b000 in IDLE and DONE.
REQ-026 err_count SHALL never exceed 8; err_count always equals popcount(err_mask).
REQ-027 Results (pass, err_count, err_mask) SHALL hold in IDLE until next accepted start.

Reset
REQ-028 reset=1 SHALL immediately force state IDLE, idx=0, x=000, busy=0, done=0, pass=0, err_count=0, err_mask=0, independent of clock.
REQ-029 reset mid-sweep SHALL discard the sweep; first start after reset release begins at vector 0.

Verification
REQ-030 Correct z_in model (TRUTH_TABLE), start pulse at edge k -> x steps 0..7, done at k+25, err_count=0, err_mask=8'h00, pass=1.
REQ-031 z_in stuck at 0 -> err_count=3, err_mask=8'b01000011, pass=0.
REQ-032 z_in stuck at 1 -> err_count=5, err_mask=8'b10111100, pass=0.
REQ-033 start re-asserted during vector 3 -> sweep unaffected, single done at k+25.
REQ-034 abort during vector 4 with stuck-at-0 z_in -> IDLE next edge, no done, err_count=2, err_mask=8'b00000011, pass=0.
REQ-035 reset asserted between edges during vector 5 -> all outputs zero at once; new start after release gives full sweep with done at start edge+25.
